// File: rtl/display_scheduler.sv
// Arbitrates the 4-digit display between the live time and a timed overlay, with optional live blink.
// All outputs except ovl_ready and owner come straight from flops.
module display_scheduler #(
   parameter int HOLD_CYCLES = 25_000_000,
   parameter int BLINK_HALF  = 6_250_000,
   parameter int CW          = 25
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [27:0] live_digits,
   input  logic        ovl_valid,
   input  logic [27:0] ovl_digits,
   output logic        ovl_ready,
   input  logic        ovl_cancel,
   output logic        ovl_done,
   input  logic        blink_en,
   output logic [6:0]  digit0_segments,
   output logic [6:0]  digit1_segments,
   output logic [6:0]  digit2_segments,
   output logic [6:0]  digit3_segments,
   output logic        owner
);

   typedef enum logic {
      LIVE = 1'b0,
      OVL  = 1'b1
   } state_t;

   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);

   state_t        state_q, state_d;
   logic [27:0]   payload_q, payload_d;
   logic [CW-1:0] hold_q, hold_d;
   logic [CW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blank_q, blank_d;
   logic          leave_q, leave_d;
   logic          done_q, done_d;
   logic [27:0]   digits_q, digits_d;

   always_comb begin
      state_d     = state_q;
      payload_d   = payload_q;
      hold_d      = hold_q;
      leave_d     = 1'b0;
      blink_cnt_d = blink_cnt_q;
      blank_d     = blank_q;

      if (state_q == LIVE) begin
         if (ovl_valid) begin
            state_d   = OVL;
            payload_d = ovl_digits;
            hold_d    = '0;
         end
      end else begin
         hold_d = hold_q + 1'b1;
         if ((hold_q == HOLD_LAST) || ovl_cancel) begin
            state_d = LIVE;
            leave_d = 1'b1;
         end
      end

      // Blink restarts from a full on-phase whenever it is disabled or an overlay owns the display.
      if (!blink_en || (state_q == OVL)) begin
         blink_cnt_d = '0;
         blank_d     = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         blank_d     = !blank_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
      end

      if (state_q == OVL) begin
         digits_d = payload_q;
      end else if (blank_q) begin
         digits_d = '0;
      end else begin
         digits_d = live_digits;
      end

      // Done is delayed one extra cycle so it lines up with the first live frame on the outputs.
      done_d = leave_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LIVE;
         payload_q   <= '0;
         hold_q      <= '0;
         blink_cnt_q <= '0;
         blank_q     <= 1'b0;
         leave_q     <= 1'b0;
         done_q      <= 1'b0;
         digits_q    <= '0;
      end else begin
         state_q     <= state_d;
         payload_q   <= payload_d;
         hold_q      <= hold_d;
         blink_cnt_q <= blink_cnt_d;
         blank_q     <= blank_d;
         leave_q     <= leave_d;
         done_q      <= done_d;
         digits_q    <= digits_d;
      end
   end

   assign ovl_ready       = (state_q == LIVE);
   assign owner           = (state_q == OVL);
   assign ovl_done        = done_q;
   assign digit0_segments = digits_q[6:0];
   assign digit1_segments = digits_q[13:7];
   assign digit2_segments = digits_q[20:14];
   assign digit3_segments = digits_q[27:21];

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler: an event-level model predicts every output frame,
// a negedge monitor pops and compares.
module tb_display_scheduler;

   localparam int HOLD  = 8;
   localparam int BLINK = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [27:0] live_digits;
   logic        ovl_valid;
   logic [27:0] ovl_digits;
   logic        ovl_ready;
   logic        ovl_cancel;
   logic        ovl_done;
   logic        blink_en;
   logic [6:0]  digit0_segments, digit1_segments, digit2_segments, digit3_segments;
   logic        owner;

   display_scheduler #(
      .HOLD_CYCLES(HOLD),
      .BLINK_HALF (BLINK),
      .CW         (25)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .live_digits    (live_digits),
      .ovl_valid      (ovl_valid),
      .ovl_digits     (ovl_digits),
      .ovl_ready      (ovl_ready),
      .ovl_cancel     (ovl_cancel),
      .ovl_done       (ovl_done),
      .blink_en       (blink_en),
      .digit0_segments(digit0_segments),
      .digit1_segments(digit1_segments),
      .digit2_segments(digit2_segments),
      .digit3_segments(digit3_segments),
      .owner          (owner)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [27:0] digits;
      logic        owner;
      logic        ready;
      logic        done;
   } exp_t;

   exp_t exp_q[$];
   int   pass_count  = 0;
   int   check_count = 0;

   // Model: overlay tracked by accept/end edge numbers, blink by length of the current live+blink run.
   bit          m_active;
   logic [27:0] m_payload;
   int          m_accept_edge;
   int          m_end_edge;
   int          m_run_len;
   int          m_edge = 0;

   function automatic void model_reset();
      m_active      = 1'b0;
      m_payload     = '0;
      m_accept_edge = 0;
      m_end_edge    = -100;
      m_run_len     = 0;
   endfunction

   function automatic exp_t reset_frame();
      exp_t e;
      e.digits = '0;
      e.owner  = 1'b0;
      e.ready  = 1'b1;
      e.done   = 1'b0;
      return e;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      if (!rst_n) begin
         model_reset();
         e = reset_frame();
      end else begin
         if (m_active)
            e.digits = m_payload;
         else if (((m_run_len / BLINK) % 2) == 1)
            e.digits = 28'h0;
         else
            e.digits = live_digits;
         e.done = (m_edge == m_end_edge + 1);
         if (!m_active && blink_en)
            m_run_len++;
         else
            m_run_len = 0;
         if (m_active) begin
            if (ovl_cancel || (m_edge == m_accept_edge + HOLD)) begin
               m_active   = 1'b0;
               m_end_edge = m_edge;
            end
         end else if (ovl_valid) begin
            m_active      = 1'b1;
            m_accept_edge = m_edge;
            m_payload     = ovl_digits;
         end
         e.owner = m_active;
         e.ready = !m_active;
      end
      m_edge++;
      exp_q.push_back(e);
   end

   task automatic checkOutput(input string name, input logic [27:0] actual, input logic [27:0] expected);
      check_count++;
      if (actual === expected)
         pass_count++;
      else
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("digits", {digit3_segments, digit2_segments, digit1_segments, digit0_segments}, e.digits);
         checkOutput("owner", 28'(owner), 28'(e.owner));
         checkOutput("ovl_ready", 28'(ovl_ready), 28'(e.ready));
         checkOutput("ovl_done", 28'(ovl_done), 28'(e.done));
      end
   end

   task automatic applyStimulus(input logic v, input logic [27:0] od, input logic c,
                                input logic b, input logic [27:0] lv);
      ovl_valid   = v;
      ovl_digits  = od;
      ovl_cancel  = c;
      blink_en    = b;
      live_digits = lv;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic b);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, 28'h0, 1'b0, b, 28'($urandom));
   endtask

   // Called at posedge+1: the frame already predicted for this cycle is replaced by the reset frame.
   task automatic doReset(input int n);
      rst_n = 1'b0;
      exp_q.delete();
      model_reset();
      exp_q.push_back(reset_frame());
      repeat (n) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic blink_state;
      rst_n       = 1'b0;
      ovl_valid   = 1'b0;
      ovl_digits  = '0;
      ovl_cancel  = 1'b0;
      blink_en    = 1'b0;
      live_digits = 28'h0FFFFFF;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) applyStimulus(1'b0, 28'h0, 1'b0, 1'b0, 28'h0FFFFFF);

      $display("[TB] overlay timeout");
      applyStimulus(1'b1, 28'h1234567, 1'b0, 1'b0, 28'($urandom));
      idle(12, 1'b0);

      $display("[TB] cancel on third overlay cycle");
      applyStimulus(1'b1, 28'h0ABCDEF, 1'b0, 1'b0, 28'($urandom));
      idle(2, 1'b0);
      applyStimulus(1'b0, 28'h0, 1'b1, 1'b0, 28'($urandom));
      idle(4, 1'b0);

      $display("[TB] cancel on hold terminal edge");
      applyStimulus(1'b1, 28'h0C0FFEE, 1'b0, 1'b0, 28'($urandom));
      idle(7, 1'b0);
      applyStimulus(1'b0, 28'h0, 1'b1, 1'b0, 28'($urandom));
      idle(4, 1'b0);

      $display("[TB] request held during overlay");
      applyStimulus(1'b1, 28'h1111111, 1'b0, 1'b0, 28'($urandom));
      for (int i = 0; i < HOLD + 1; i++)
         applyStimulus(1'b1, 28'h2222222, 1'b0, 1'b0, 28'($urandom));
      idle(12, 1'b0);

      $display("[TB] blink with overlay mid-blink");
      idle(13, 1'b1);
      applyStimulus(1'b1, 28'h0555555, 1'b0, 1'b1, 28'($urandom));
      idle(22, 1'b1);
      idle(3, 1'b0);

      $display("[TB] reset mid-overlay");
      applyStimulus(1'b1, 28'h0777777, 1'b0, 1'b0, 28'($urandom));
      idle(3, 1'b0);
      doReset(2);
      idle(12, 1'b0);

      $display("[TB] random traffic");
      blink_state = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0)
            blink_state = ~blink_state;
         applyStimulus($urandom_range(0, 3) == 0, 28'($urandom), $urandom_range(0, 15) == 0,
                       blink_state, 28'($urandom));
      end
      idle(3, 1'b0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Shares the stopwatch's single 4-digit seven-segment display between the live time source and a one-shot overlay source (lap time, mode message). Sits directly upstream of the 4-digit driver: its registered per-digit segment outputs feed that driver's digit inputs. It also blinks the live display on request. A valid/ready handshake accepts overlays, and a done pulse reports when each overlay ends.

## Interface
- HOLD_CYCLES, 25_000_000: cycles an accepted overlay stays on the display (1 s at 25 MHz); must be ≥ 2.
- BLINK_HALF, 6_250_000: cycles per blink half-period (on or off); must be ≥ 1.
- CW, 25: width of the hold and blink counters; must hold HOLD_CYCLES-1 and BLINK_HALF-1.
- clk  in  1  25 MHz system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- live_digits  in  28  live time, {digit3,digit2,digit1,digit0}, 7 segments each, active-high, sampled every cycle.
- ovl_valid  in  1  overlay request; held with stable ovl_digits until accepted.
- ovl_digits  in  28  overlay payload, same packing as live_digits.
- ovl_ready  out  1  block can accept an overlay this cycle.
- ovl_cancel  in  1  ends an active overlay early; ignored in LIVE.
- ovl_done  out  1  one-cycle pulse when an overlay ends (timeout or cancel).
- blink_en  in  1  blink the live display; no effect on overlays.
- digit0_segments..digit3_segments  out  7 each  registered active-high segment patterns to the driver.
- owner  out  1  0 = live source, 1 = overlay (decode of state).

## Operation
- Two-state FSM: LIVE, OVL. Reset state is LIVE.
- ovl_ready = (state == LIVE). It is a combinational decode.
- Accept: ovl_valid && ovl_ready at a rising edge. On that edge:
  - ovl_digits is latched into a 28-bit payload register.
  - The hold counter clears to 0.
  - The state becomes OVL.
- OVL behaviour:
  - The hold counter increments each cycle.
  - At the edge where count == HOLD_CYCLES-1, or where ovl_cancel is sampled high, the state becomes LIVE.
  - If both happen on the same edge, there is exactly one transition and one done pulse.
  - ovl_valid is ignored, and the payload is not overwritten.
- ovl_done is a registered signal. It is high for exactly the first cycle after leaving OVL. Leaving OVL by reset does not assert it.
- Back-to-back overlays: in the first LIVE cycle, ovl_ready=1. An overlay can be accepted in that cycle, so the minimum gap in LIVE is 1 cycle.
- Blink:
  - The blink counter and phase are cleared (phase = on) whenever blink_en=0 or state=OVL.
  - Otherwise the counter counts 0..BLINK_HALF-1, wraps, and toggles the phase at the wrap.
  - The first on-phase after blink_en rises lasts BLINK_HALF cycles.
- Output register, loaded every cycle from the current state:
  - In OVL, it loads the payload.
  - In LIVE with phase = off, it loads all zeros (blank).
  - Otherwise it loads live_digits.
- Reset (asynchronous, any time, including mid-overlay), all registers clear:
  - State = LIVE, payload = 0, counters = 0, phase = on.
  - ovl_done = 0, all digit outputs = 7'b0000000 (blank).
  - Hence owner = 0 and ovl_ready = 1.

## Timing
- Live path latency: a live_digits change sampled at edge k appears on the outputs after edge k (1 cycle).
- Overlay path, with accept at edge k:
  - owner=1 and ovl_ready=0 from edge k.
  - Outputs show the payload from edge k+1.
  - The state returns to LIVE at edge k+HOLD_CYCLES, so OVL lasts exactly HOLD_CYCLES cycles.
  - Outputs show live or blank data from edge k+HOLD_CYCLES+1.
  - ovl_done is high from edge k+HOLD_CYCLES+1 to k+HOLD_CYCLES+2.
- Cancel sampled at edge j while in OVL: LIVE from edge j, and ovl_done is high for the cycle after edge j+1.
- Blink period: 2·BLINK_HALF cycles. Output blanking lags the phase register by 1 cycle.

## Test plan
Bench parameters for all scenarios: HOLD_CYCLES=8, BLINK_HALF=4.
- Reset: set live_digits=28'h0FFFFFF, hold rst_n low, then release → all digits 0, owner=0, ovl_ready=1, ovl_done=0 during reset. After release, the outputs show the live value one cycle later.
- Overlay timeout: accept ovl_digits=28'h1234567 at edge k → ovl_ready=0 from k. Outputs equal 28'h1234567 for exactly 8 cycles from k+1, then return to live. Exactly one ovl_done pulse at k+9.
- Cancel and collision: cancel at the 3rd OVL cycle → return to LIVE with one done pulse. Separately, cancel on the hold terminal edge → a single done pulse and no extra cycle in OVL.
- Request during OVL: hold ovl_valid high with a new payload throughout an overlay → the payload is unchanged. The second overlay is accepted in the first LIVE cycle and shows immediately after.
- Blink: blink_en=1 in LIVE → outputs show live for 4 cycles, blank for 4, repeating. An overlay accepted mid-blink shows unblanked. After the overlay, blinking restarts with a 4-cycle on-phase.
- Reset mid-overlay: assert rst_n low during OVL → immediate LIVE, blank outputs, and no ovl_done pulse after release.
